gf2m_inv163: RTL and testbench

- Iterative GF(2^163) inverter: computes c = a^-1 mod P(x), where P(x) = x^163 + x^7 + x^6 + x^3 + 1.
- It is the inverse-direction companion to the team's GF(2^163) multiplier.
- ECC point arithmetic uses it for affine conversion and division; the multiplier is used to check its results.
- Method: binary extended Euclid, one iteration per clock, valid/ready handshake on both sides.

---
 rtl/gf2m_inv163.sv | 136 +++++++++++++
 tb/tb_gf2m_inv163.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/gf2m_inv163.sv
// GF(2^163) inverter, P(x) = x^163 + x^7 + x^6 + x^3 + 1, binary extended Euclid.
// One iteration per clock; valid/ready on the operand and result sides.
module gf2m_inv163 #(
  parameter int         M    = 163,
  parameter logic [M:0] POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] c,
  output logic         err
);

  localparam logic [8:0] WD_LIM = 9'(2 * M + 1);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t       r_state, w_state_nxt;
  logic [M-1:0] r_u, r_g1, r_g2, r_c;
  logic [M:0]   r_v;
  logic [7:0]   r_du, r_dv;
  logic [8:0]   r_wd;
  logic         r_err;

  logic [M:0]   w_uv;
  logic [M-1:0] w_g12;
  logic         w_u_one, w_v_one, w_wd_exp, w_a_zero;

  function automatic logic [7:0] deg(input logic [M-1:0] x);
    deg = 8'd0;
    for (int i = 0; i < M; i++)
      if (x[i]) deg = 8'(i);
  endfunction

  // Division by x modulo P: fold P in first when the constant term is set.
  function automatic logic [M-1:0] div_x(input logic [M-1:0] g);
    logic [M:0] t;
    t = g[0] ? ({1'b0, g} ^ POLY) : {1'b0, g};
    div_x = t[M:1];
  endfunction

  assign w_uv     = {1'b0, r_u} ^ r_v;
  assign w_g12    = r_g1 ^ r_g2;
  assign w_u_one  = (r_u == M'(1));
  assign w_v_one  = (r_v == (M+1)'(1));
  assign w_wd_exp = (r_wd == WD_LIM);
  assign w_a_zero = (a == '0);

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign c         = r_c;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (in_valid) w_state_nxt = w_a_zero ? DONE : ITER;
      ITER: if (w_u_one || w_v_one || w_wd_exp) w_state_nxt = DONE;
      DONE: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_u   <= '0;
      r_v   <= '0;
      r_g1  <= '0;
      r_g2  <= '0;
      r_du  <= '0;
      r_dv  <= '0;
      r_wd  <= '0;
      r_c   <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            if (w_a_zero) begin
              r_c   <= '0;
              r_err <= 1'b1;
            end else begin
              r_u   <= a;
              r_v   <= POLY;
              r_g1  <= M'(1);
              r_g2  <= '0;
              r_du  <= deg(a);
              r_dv  <= 8'(M);
              r_wd  <= '0;
              r_err <= 1'b0;
            end
          end
        end
        ITER: begin
          r_wd <= r_wd + 9'd1;
          if (w_u_one) begin
            r_c <= r_g1;
          end else if (w_v_one) begin
            r_c <= r_g2;
          end else if (w_wd_exp) begin
            r_c   <= '0;
            r_err <= 1'b1;
          end else if (!r_u[0]) begin
            r_u  <= r_u >> 1;
            r_g1 <= div_x(r_g1);
            r_du <= r_du - 8'd1;
          end else if (!r_v[0]) begin
            r_v  <= r_v >> 1;
            r_g2 <= div_x(r_g2);
            r_dv <= r_dv - 8'd1;
          end else if (r_du >= r_dv) begin
            // du >= dv implies deg(v) < 163, so bit M of u^v is zero here
            r_u  <= w_uv[M:1];
            r_g1 <= div_x(w_g12);
            r_du <= r_du - 8'd1;
          end else begin
            r_v  <= {1'b0, w_uv[M:1]};
            r_g2 <= div_x(w_g12);
            r_dv <= r_dv - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_inv163.sv
// Bench for gf2m_inv163: results verified by multiplying back with a
// behavioural GF(2^163) multiplier, plus fixed vectors and protocol checks.
module tb_gf2m_inv163;

  localparam int         M    = 163;
  localparam logic [M:0] POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9;
  localparam int         LAT_MAX = 2 * M + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] a = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [M-1:0] c;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;

  gf2m_inv163 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [M:0] obs, input logic [M:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Shift-and-add polynomial product reduced modulo P.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [M:0] p;
    p = '0;
    for (int i = M - 1; i >= 0; i--) begin
      p = p << 1;
      if (p[M]) p = p ^ POLY;
      if (y[i]) p = p ^ {1'b0, x};
    end
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] rand_nz();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (t[M-1:0] == '0) t[0] = 1'b1;
    return t[M-1:0];
  endfunction

  task automatic start_op(input logic [M-1:0] av);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    a = av;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [M-1:0] av, output logic [M-1:0] cv,
                        output logic ev, output int lat);
    start_op(av);
    lat = 1;
    while (!out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check("out_valid_seen", out_valid, 1);
    cv = c;
    ev = err;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("ov_after_hs", out_valid, 0);
    check("ir_after_hs", in_ready, 1);
  endtask

  task automatic verify(input string tag, input logic [M-1:0] av);
    logic [M-1:0] cv;
    logic ev;
    int lat;
    run_op(av, cv, ev, lat);
    check({tag, "_prod"}, gf_mul(av, cv), 1);
    check({tag, "_err"}, ev, 0);
    check({tag, "_lat"}, (lat <= LAT_MAX), 1);
    finish_op();
  endtask

  initial begin
    logic [M-1:0] cv, c_hold, av;
    logic ev, e_hold;
    int lat;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_c", c, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    // a = 1
    run_op(M'(1), cv, ev, lat);
    check("one_c", cv, 1);
    check("one_err", ev, 0);
    check("one_lat", (lat <= 2), 1);
    finish_op();

    // a = x and back
    run_op(M'(2), cv, ev, lat);
    check("x_c", cv, 163'h4_0000_0000_0000_0000_0000_0000_0000_0000_0000_0064);
    check("x_err", ev, 0);
    finish_op();
    run_op(163'h4_0000_0000_0000_0000_0000_0000_0000_0000_0000_0064, cv, ev, lat);
    check("xinv_c", cv, 2);
    finish_op();

    // a = 0
    run_op('0, cv, ev, lat);
    check("zero_lat", lat, 1);
    check("zero_err", ev, 1);
    check("zero_c", cv, 0);
    finish_op();

    verify("top_bit", {1'b1, {(M-1){1'b0}}});
    verify("all_ones", '1);
    verify("poly_low", POLY[M-1:0]);

    for (int k = 0; k < 150; k++) verify("rand", rand_nz());

    // Backpressure: result must hold and new operands must be ignored
    av = rand_nz();
    run_op(av, c_hold, e_hold, lat);
    check("bp_prod", gf_mul(av, c_hold), 1);
    for (int k = 0; k < 20; k++) begin
      in_valid = k[0];
      a = rand_nz();
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_c", c, {1'b0, c_hold});
      check("bp_err", err, e_hold);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    finish_op();

    // Asynchronous reset in the middle of an iteration run
    start_op(rand_nz());
    repeat (49) @(negedge clk);
    check("mid_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    verify("after_rst", M'(3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
